// File: rtl/prog_loader.sv
// ============================================================================
// Module      : prog_loader
// Description : Loads the CPU instruction memory from a framed byte stream.
//               Frame: SYNC, LEN_LO, LEN_HI, 2*LEN data bytes, CHK.
//               Each word is written low byte first. The CPU is held in reset
//               while a frame loads and is released only when the checksum
//               matches.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module prog_loader #(
  parameter int          ADDR_W       = 11,
  parameter int          DATA_W       = 16,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter logic [23:0] TIMEOUT_CYC  = 24'd1_000_000,
  parameter bit          RUN_AT_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_din,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   words_written
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LEN_LO = 4'd1,
    S_LEN_HI = 4'd2,
    S_D_LO   = 4'd3,
    S_D_HI   = 4'd4,
    S_WRITE  = 4'd5,
    S_CHK    = 4'd6,
    S_DONE   = 4'd7,
    S_ERR    = 4'd8
  } state_t;

  localparam logic [1:0]  ERR_NONE = 2'b00;
  localparam logic [1:0]  ERR_LEN  = 2'b01;
  localparam logic [1:0]  ERR_CHK  = 2'b10;
  localparam logic [1:0]  ERR_TMO  = 2'b11;
  // Largest legal word count: one full memory.
  localparam logic [31:0] LEN_MAX  = 32'd1 << ADDR_W;

  state_t              state;
  logic [7:0]          len_lo;
  logic [ADDR_W:0]     len_q;
  logic [ADDR_W-1:0]   addr;
  logic [7:0]          lo_byte;
  logic [7:0]          csum;
  logic [23:0]         idle_cnt;

  logic                accept;
  logic                in_frame;
  logic                timeout_hit;
  logic [31:0]         len_full;
  logic                len_bad;
  logic [ADDR_W:0]     ww_next;

  assign accept   = in_valid & in_ready;
  assign in_frame = state inside {S_LEN_LO, S_LEN_HI, S_D_LO, S_D_HI, S_WRITE, S_CHK};
  // WRITE never accepts a byte, so it is left out; an accepted byte at the
  // limit beats the timeout.
  assign timeout_hit = (state inside {S_LEN_LO, S_LEN_HI, S_D_LO, S_D_HI, S_CHK}) &&
                       !accept && (idle_cnt >= TIMEOUT_CYC - 24'd1);
  assign len_full = {16'd0, in_data, len_lo};
  assign len_bad  = (len_full == 32'd0) || (len_full > LEN_MAX);
  assign ww_next  = words_written + 1'b1;

  // Idle-cycle counter: runs only inside a frame, cleared by every accepted byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= 24'd0;
    end else if (!in_frame || accept) begin
      idle_cnt <= 24'd0;
    end else begin
      idle_cnt <= idle_cnt + 24'd1;
    end
  end

  // Frame parser, memory writer and status outputs (all registered).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      in_ready      <= 1'b1;
      mem_we        <= 1'b0;
      mem_adr       <= '0;
      mem_din       <= '0;
      cpu_rst_n     <= RUN_AT_RESET;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      err_code      <= ERR_NONE;
      words_written <= '0;
      len_lo        <= 8'd0;
      len_q         <= '0;
      addr          <= '0;
      lo_byte       <= 8'd0;
      csum          <= 8'd0;
    end else if (timeout_hit) begin
      state    <= S_ERR;
      busy     <= 1'b0;
      err      <= 1'b1;
      err_code <= ERR_TMO;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          // Non-sync bytes are accepted and dropped.
          if (accept && (in_data == SYNC_BYTE)) begin
            state         <= S_LEN_LO;
            cpu_rst_n     <= 1'b0;
            busy          <= 1'b1;
            done          <= 1'b0;
            err           <= 1'b0;
            err_code      <= ERR_NONE;
            words_written <= '0;
            csum          <= 8'd0;
            addr          <= '0;
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            len_lo <= in_data;
            state  <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            if (len_bad) begin
              state    <= S_ERR;
              busy     <= 1'b0;
              err      <= 1'b1;
              err_code <= ERR_LEN;
            end else begin
              len_q <= len_full[ADDR_W:0];
              state <= S_D_LO;
            end
          end
        end
        S_D_LO: begin
          if (accept) begin
            lo_byte <= in_data;
            csum    <= csum + in_data;
            state   <= S_D_HI;
          end
        end
        S_D_HI: begin
          if (accept) begin
            csum     <= csum + in_data;
            mem_we   <= 1'b1;
            mem_adr  <= addr;
            mem_din  <= {in_data, lo_byte};
            in_ready <= 1'b0;
            state    <= S_WRITE;
          end
        end
        S_WRITE: begin
          // addr wraps to 0 only after the final word of a full-size frame,
          // where it is no longer used.
          mem_we        <= 1'b0;
          in_ready      <= 1'b1;
          addr          <= addr + 1'b1;
          words_written <= ww_next;
          state         <= (ww_next == len_q) ? S_CHK : S_D_LO;
        end
        S_CHK: begin
          if (accept) begin
            busy <= 1'b0;
            if (in_data == csum) begin
              state     <= S_DONE;
              done      <= 1'b1;
              cpu_rst_n <= 1'b1;
            end else begin
              state    <= S_ERR;
              err      <= 1'b1;
              err_code <= ERR_CHK;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
// Module      : tb_prog_loader
// Description : Self-checking bench for prog_loader: table of whole frames
//               plus hand-written timeout, reset and full-length sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_prog_loader;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [10:0] mem_adr;
  logic [15:0] mem_din;
  logic        cpu_rst_n;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [11:0] words_written;

  int n_chk = 0;
  int n_fail = 0;

  // Write monitor state
  logic [15:0] mem_model [2048];
  int          nwr = 0;
  int          dbl_we = 0;
  logic        prev_we = 1'b0;
  logic [10:0] w_adr [2];
  logic [15:0] w_dat [2];

  prog_loader #(
    .ADDR_W(11), .DATA_W(16), .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYC(24'd16), .RUN_AT_RESET(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_adr(mem_adr), .mem_din(mem_din),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err),
    .err_code(err_code), .words_written(words_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write strobe, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      if (prev_we) dbl_we++;
      mem_model[mem_adr] = mem_din;
      if (nwr < 2) begin
        w_adr[nwr] = mem_adr;
        w_dat[nwr] = mem_din;
      end
      nwr++;
    end
    prev_we = mem_we;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Present one byte and return #1 after the edge that accepts it.
  task automatic send(input logic [7:0] b);
    logic ok;
    int   cyc;
    ok  = 1'b0;
    cyc = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!ok && cyc < 50) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      cyc++;
    end
    #1;
    in_valid = 1'b0;
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL send: byte %0h not accepted, in_ready %0b required 1", b, in_ready);
    end
  endtask

  typedef struct {
    int          n;
    logic [79:0] bytes;   // first byte in the top 8 bits
    logic        exp_done;
    logic        exp_err;
    logic [1:0]  exp_code;
    logic [11:0] exp_ww;
    logic        exp_cpu;
    int          exp_nwr;
    logic [15:0] exp_d0;
    logic [15:0] exp_d1;
  } vec_t;

  vec_t vecs [6];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0]  lo, hi, sum;
    logic [15:0] exp_w;
    int          bad;

    vecs[0] = '{8, 80'hA5_02_00_11_22_33_44_AA_00_00, 1'b1, 1'b0, 2'b00, 12'd2, 1'b1, 2, 16'h2211, 16'h4433};
    vecs[1] = '{8, 80'hA5_02_00_11_22_33_44_AB_00_00, 1'b0, 1'b1, 2'b10, 12'd2, 1'b0, 2, 16'h2211, 16'h4433};
    vecs[2] = '{8, 80'hA5_02_00_11_22_33_44_AA_00_00, 1'b1, 1'b0, 2'b00, 12'd2, 1'b1, 2, 16'h2211, 16'h4433};
    vecs[3] = '{3, 80'hA5_00_00_00_00_00_00_00_00_00, 1'b0, 1'b1, 2'b01, 12'd0, 1'b0, 0, 16'h0000, 16'h0000};
    vecs[4] = '{3, 80'hA5_01_08_00_00_00_00_00_00_00, 1'b0, 1'b1, 2'b01, 12'd0, 1'b0, 0, 16'h0000, 16'h0000};
    vecs[5] = '{9, 80'h00_FF_12_A5_01_00_CD_AB_78_00, 1'b1, 1'b0, 2'b00, 12'd1, 1'b1, 1, 16'hABCD, 16'h0000};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    chk("rst cpu_rst_n", cpu_rst_n, 1);
    chk("rst in_ready", in_ready, 1);
    chk("rst mem_we", mem_we, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    chk("rst err_code", err_code, 0);
    chk("rst words", words_written, 0);

    // Table of complete frames
    for (int v = 0; v < 6; v++) begin
      nwr = 0;
      for (int i = 0; i < vecs[v].n; i++) begin
        send(vecs[v].bytes[79-8*i -: 8]);
      end
      chk($sformatf("v%0d done", v), done, vecs[v].exp_done);
      chk($sformatf("v%0d err", v), err, vecs[v].exp_err);
      chk($sformatf("v%0d err_code", v), err_code, vecs[v].exp_code);
      chk($sformatf("v%0d words", v), words_written, vecs[v].exp_ww);
      chk($sformatf("v%0d cpu_rst_n", v), cpu_rst_n, vecs[v].exp_cpu);
      chk($sformatf("v%0d busy", v), busy, 0);
      chk($sformatf("v%0d writes", v), nwr, vecs[v].exp_nwr);
      if (vecs[v].exp_nwr >= 1) begin
        chk($sformatf("v%0d adr0", v), w_adr[0], 0);
        chk($sformatf("v%0d din0", v), w_dat[0], vecs[v].exp_d0);
      end
      if (vecs[v].exp_nwr >= 2) begin
        chk($sformatf("v%0d adr1", v), w_adr[1], 1);
        chk($sformatf("v%0d din1", v), w_dat[1], vecs[v].exp_d1);
      end
    end

    // Reset in the middle of a frame; also check cpu_rst_n falls on sync and write latency
    nwr = 0;
    send(8'hA5);
    chk("sync cpu_rst_n", cpu_rst_n, 0);
    chk("sync busy", busy, 1);
    chk("sync done", done, 0);
    send(8'h01);
    send(8'h00);
    send(8'h11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid rst mem_we", mem_we, 0);
    chk("mid rst mem_adr", mem_adr, 0);
    chk("mid rst mem_din", mem_din, 0);
    chk("mid rst cpu_rst_n", cpu_rst_n, 1);
    chk("mid rst busy", busy, 0);
    chk("mid rst err", err, 0);
    chk("mid rst err_code", err_code, 0);
    chk("mid rst words", words_written, 0);
    chk("mid rst in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mid rst writes", nwr, 0);
    chk("mid rst mem0 kept", mem_model[0], 16'hABCD);

    // Byte accepted exactly at the timeout limit wins
    nwr = 0;
    send(8'hA5);
    send(8'h01);
    send(8'h00);
    repeat (15) @(posedge clk);
    #1;
    send(8'h34);
    chk("limit busy", busy, 1);
    chk("limit err", err, 0);
    send(8'h12);
    chk("latency mem_we", mem_we, 1);
    chk("latency mem_din", mem_din, 16'h1234);
    @(posedge clk);
    #1;
    chk("strobe width", mem_we, 0);
    send(8'h46);
    chk("limit done", done, 1);

    // Timeout after 16 idle cycles inside a frame
    nwr = 0;
    send(8'hA5);
    send(8'h01);
    send(8'h00);
    send(8'h34);
    repeat (15) @(posedge clk);
    #1;
    chk("tmo 15 busy", busy, 1);
    chk("tmo 15 err", err, 0);
    @(posedge clk);
    #1;
    chk("tmo err", err, 1);
    chk("tmo err_code", err_code, 2'b11);
    chk("tmo busy", busy, 0);
    chk("tmo cpu_rst_n", cpu_rst_n, 0);
    chk("tmo writes", nwr, 0);

    // Full-size frame: LEN = 2048
    nwr = 0;
    sum = 8'h00;
    send(8'hA5);
    send(8'h00);
    send(8'h08);
    for (int i = 0; i < 2048; i++) begin
      lo = i[7:0] ^ 8'h5A;
      hi = i[10:3];
      sum = sum + lo + hi;
      send(lo);
      send(hi);
    end
    send(sum);
    chk("full done", done, 1);
    chk("full err", err, 0);
    chk("full words", words_written, 12'h800);
    chk("full writes", nwr, 2048);
    chk("full cpu_rst_n", cpu_rst_n, 1);
    bad = 0;
    for (int i = 0; i < 2048; i++) begin
      lo = i[7:0] ^ 8'h5A;
      hi = i[10:3];
      exp_w = {hi, lo};
      if (mem_model[i] !== exp_w) bad++;
    end
    chk("full mem contents", bad, 0);
    chk("single-cycle strobes", dbl_we, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
